// File: rtl/uart_link_scheduler_if.sv
// WISHBONE-style bus between the link scheduler (master) and the MiniUART slave port.
interface uart_link_scheduler_if;
   logic [2:0]  ADD_O;
   logic [31:0] DAT_O;
   logic [31:0] DAT_I;
   logic        STB_O;
   logic        WE_O;
   logic        ACK_I;

   modport master (
      output ADD_O,
      output DAT_O,
      output STB_O,
      output WE_O,
      input  DAT_I,
      input  ACK_I
   );

   modport slave (
      input  ADD_O,
      input  DAT_O,
      input  STB_O,
      input  WE_O,
      output DAT_I,
      output ACK_I
   );
endinterface

// File: rtl/uart_link_scheduler.sv
// Bus master in front of MiniUART: programs the divisors, polls LSR, drains received
// bytes into a one-entry buffer and shares the transmitter between two byte requesters.
module uart_link_scheduler #(
   parameter logic [15:0] DIVR_INIT  = 16'd326,
   parameter logic [15:0] DIVT_INIT  = 16'd5208,
   parameter logic [2:0]  OFF_DATA   = 3'd0,
   parameter logic [2:0]  OFF_LSR    = 3'd1,
   parameter logic [2:0]  OFF_DIVR   = 3'd2,
   parameter logic [2:0]  OFF_DIVT   = 3'd3,
   parameter int unsigned SETTLE_CYC = 8
) (
   input  logic                          CLK_I,
   input  logic                          RST_I,
   input  logic                          req0_valid,
   input  logic [7:0]                    req0_data,
   output logic                          req0_ready,
   input  logic                          req1_valid,
   input  logic [7:0]                    req1_data,
   output logic                          req1_ready,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   uart_link_scheduler_if.master         bus,
   output logic                          cfg_done
);

   typedef enum logic [2:0] {
      ST_RST,
      ST_CFG_R,
      ST_CFG_T,
      ST_POLL,
      ST_RX_RD,
      ST_TX_WR,
      ST_SETTLE
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [7:0]  tx_hold;
   logic        last_grant;
   logic [7:0]  settle_cnt;

   logic        stb;
   logic        we;
   logic [2:0]  add;
   logic [31:0] dat;
   logic        tx_take;
   logic        grant_sel;
   logic        lsr_rs;
   logic        lsr_ts;
   logic        dat_unused;

   assign lsr_rs     = bus.DAT_I[0];
   assign lsr_ts     = bus.DAT_I[5];
   assign dat_unused = ^bus.DAT_I[31:8];

   assign bus.STB_O = stb;
   assign bus.WE_O  = we;
   assign bus.ADD_O = add;
   assign bus.DAT_O = dat;

   // Strict alternation on contention; last_grant resets to 1 so requester 0 wins first.
   always_comb begin
      grant_sel = req1_valid;
      if (req0_valid && req1_valid) begin
         grant_sel = ~last_grant;
      end
   end

   always_comb begin
      state_next = state;
      stb        = 1'b0;
      we         = 1'b0;
      add        = 3'd0;
      dat        = 32'd0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      tx_take    = 1'b0;
      case (state)
         ST_RST: begin
            state_next = ST_CFG_R;
         end
         ST_CFG_R: begin
            stb = 1'b1;
            we  = 1'b1;
            add = OFF_DIVR;
            dat = {16'd0, DIVR_INIT};
            if (bus.ACK_I) begin
               state_next = ST_CFG_T;
            end
         end
         ST_CFG_T: begin
            stb = 1'b1;
            we  = 1'b1;
            add = OFF_DIVT;
            dat = {16'd0, DIVT_INIT};
            if (bus.ACK_I) begin
               state_next = ST_POLL;
            end
         end
         // A pending rx byte beats a pending tx byte; the tx is granted on a later poll.
         ST_POLL: begin
            stb = 1'b1;
            add = OFF_LSR;
            if (bus.ACK_I) begin
               if (lsr_rs && !rx_valid) begin
                  state_next = ST_RX_RD;
               end else if (lsr_ts && (req0_valid || req1_valid)) begin
                  tx_take    = 1'b1;
                  state_next = ST_TX_WR;
               end
            end
         end
         ST_RX_RD: begin
            stb = 1'b1;
            add = OFF_DATA;
            if (bus.ACK_I) begin
               state_next = ST_POLL;
            end
         end
         ST_TX_WR: begin
            stb        = 1'b1;
            we         = 1'b1;
            add        = OFF_DATA;
            dat        = {24'd0, tx_hold};
            req0_ready = ~last_grant;
            req1_ready = last_grant;
            if (bus.ACK_I) begin
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt == 8'd0) begin
               state_next = ST_POLL;
            end
         end
         default: begin
            state_next = ST_RST;
         end
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (!RST_I) begin
         state      <= ST_RST;
         tx_hold    <= 8'd0;
         last_grant <= 1'b1;
         settle_cnt <= 8'd0;
         cfg_done   <= 1'b0;
         rx_valid   <= 1'b0;
         rx_data    <= 8'd0;
      end else begin
         state <= state_next;
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (state == ST_CFG_T && bus.ACK_I) begin
            cfg_done <= 1'b1;
         end
         if (tx_take) begin
            tx_hold    <= grant_sel ? req1_data : req0_data;
            last_grant <= grant_sel;
         end
         if (state == ST_RX_RD && bus.ACK_I) begin
            rx_data  <= bus.DAT_I[7:0];
            rx_valid <= 1'b1;
         end
         // Counter is loaded so that SETTLE lasts exactly SETTLE_CYC cycles.
         if (state == ST_TX_WR && bus.ACK_I) begin
            settle_cnt <= 8'(SETTLE_CYC - 1);
         end else if (state == ST_SETTLE && settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
         end
      end
   end

endmodule
